// File: rtl/lif_pkg.sv
// Shared definitions for the spiking-network output path: default sizes,
// the drain state encoding and a saturating increment helper.
package lif_pkg;

    localparam int N_CH_DEF  = 8;
    localparam int CNT_W_DEF = 8;
    localparam int WIN_W_DEF = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_e;

    // Increment val by one unless it already sits at max_val.
    function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                            input logic [31:0] max_val);
        return (val >= max_val) ? max_val : val + 32'd1;
    endfunction

endpackage

// File: rtl/spike_counter.sv
// One per-channel saturating spike accumulator. next_o is the count that
// includes this cycle's spike, so the owner can snapshot it on the same
// cycle that clear_i wipes the register.
module spike_counter
    import lif_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             inc_i,
    input  logic             clear_i,
    output logic [CNT_W-1:0] next_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Count including the current spike, saturated at all-ones.
    always_comb begin
        next_o = count_q;
        if (en_i && inc_i) begin
            next_o = CNT_W'(sat_inc(32'(count_q), 32'({CNT_W{1'b1}})));
        end
        count_d = clear_i ? '0 : next_o;
    end

    // Accumulator register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/spike_rate_decoder.sv
// Counts spikes per channel over a programmable window, snapshots the counts
// at each window end and streams them out one channel per valid/ready beat.
// Handshake: an entry transfers on a cycle where out_valid && out_ready; the
// entry fields hold stable while out_valid is high and out_ready is low, and
// out_valid only falls after the handshake of the last channel (or reset).
module spike_rate_decoder
    import lif_pkg::*;
#(
    parameter  int N_CH  = N_CH_DEF,
    parameter  int CNT_W = CNT_W_DEF,
    parameter  int WIN_W = WIN_W_DEF,
    localparam int IDX_W = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [N_CH-1:0]  spike_in,
    input  logic [WIN_W-1:0] win_len,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_ch,
    output logic [CNT_W-1:0] out_count,
    output logic             out_last,
    output logic             overrun,
    output drain_state_e     dbg_state_o
);

    // ---------------- window counter ----------------
    logic             fresh_q;     // first cycle after reset: latch win_len directly
    logic [WIN_W-1:0] len_q, len_d;
    logic [WIN_W-1:0] wc_q, wc_d;
    logic [WIN_W-1:0] win_eff, len_cur;
    logic             eow;

    assign win_eff = (win_len == '0) ? WIN_W'(1) : win_len;
    assign len_cur = fresh_q ? win_eff : len_q;
    assign eow     = ena && (wc_q == len_cur - WIN_W'(1));

    // Next window position and the length latched for the next window.
    always_comb begin
        wc_d  = wc_q;
        len_d = len_cur;
        if (eow) begin
            wc_d  = '0;
            len_d = win_eff;
        end else if (ena) begin
            wc_d = wc_q + WIN_W'(1);
        end
    end

    // Window counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fresh_q <= 1'b1;
            len_q   <= WIN_W'(1);
            wc_q    <= '0;
        end else begin
            fresh_q <= 1'b0;
            len_q   <= len_d;
            wc_q    <= wc_d;
        end
    end

    // ---------------- channel accumulators ----------------
    logic [CNT_W-1:0] final_cnt [N_CH];

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        spike_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk     (clk),
            .rst_n   (rst_n),
            .en_i    (ena),
            .inc_i   (spike_in[g]),
            .clear_i (eow),
            .next_o  (final_cnt[g])
        );
    end

    // ---------------- snapshot and drain FSM ----------------
    drain_state_e     state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] snap_q [N_CH];
    logic [CNT_W-1:0] snap_d [N_CH];
    logic [CNT_W-1:0] count_q, count_d;
    logic             last_q, last_d;
    logic             overrun_q, overrun_d;
    logic             hs, final_hs;

    assign out_valid   = (state_q == DRAIN);
    assign out_ch      = idx_q;
    assign out_count   = count_q;
    assign out_last    = last_q;
    assign overrun     = overrun_q;
    assign dbg_state_o = state_q;
    assign hs          = out_valid && out_ready;
    assign final_hs    = hs && last_q;

    // Next-state logic: snapshot on window end, advance on handshake, and
    // drop a window that ends while the previous one is still draining.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        snap_d    = snap_q;
        overrun_d = overrun_q;
        case (state_q)
            IDLE: begin
                if (eow) begin
                    for (int i = 0; i < N_CH; i++) snap_d[i] = final_cnt[i];
                    idx_d   = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (hs) begin
                    if (last_q) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                if (eow) begin
                    if (final_hs) begin
                        for (int i = 0; i < N_CH; i++) snap_d[i] = final_cnt[i];
                        idx_d   = '0;
                        state_d = DRAIN;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        count_d = snap_d[idx_d];
        last_d  = (state_d == DRAIN) && (idx_d == IDX_W'(N_CH - 1));
    end

    // FSM, snapshot and registered output fields.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            count_q   <= '0;
            last_q    <= 1'b0;
            overrun_q <= 1'b0;
            for (int i = 0; i < N_CH; i++) snap_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            count_q   <= count_d;
            last_q    <= last_d;
            overrun_q <= overrun_d;
            for (int i = 0; i < N_CH; i++) snap_q[i] <= snap_d[i];
        end
    end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder. Cycle 0 is the first cycle with
// rst_n=1; "observed in cycle c" means sampled 1ns after the edge that
// ends cycle c-1, and inputs written at that point apply to cycle c.
module tb_spike_rate_decoder;
    import lif_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ena = 1'b0;
    logic [7:0]   spike_in = '0;
    logic [15:0]  win_len = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [2:0]   out_ch;
    logic [7:0]   out_count;
    logic         out_last;
    logic         overrun;
    drain_state_e dbg_state;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    spike_rate_decoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .spike_in    (spike_in),
        .win_len     (win_len),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_ch      (out_ch),
        .out_count   (out_count),
        .out_last    (out_last),
        .overrun     (overrun),
        .dbg_state_o (dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic test_reset();
        win_len = 16'd5; spike_in = 8'hFF; ena = 1'b1; out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
        checks++; if (out_ch !== 3'd0) begin failures++; $display("FAIL reset_ch got=%0d exp=0", out_ch); end
        checks++; if (out_count !== 8'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", out_count); end
        checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_last got=%0b exp=0", out_last); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%0b exp=0", overrun); end
        checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=IDLE", dbg_state); end
    endtask

    // win_len=10, ch0 spikes every cycle: entries in cycles 10..17.
    task automatic test_basic();
        logic       e_valid;
        logic [2:0] e_ch;
        logic [7:0] e_cnt;
        win_len = 16'd10; spike_in = 8'h01; ena = 1'b1; out_ready = 1'b1;
        do_reset();
        while (cyc < 20) begin
            e_valid = (cyc >= 10) && (cyc <= 17);
            checks++; if (out_valid !== e_valid) begin failures++; $display("FAIL basic_valid cyc=%0d got=%0b exp=%0b", cyc, out_valid, e_valid); end
            if (e_valid) begin
                e_ch  = 3'(cyc - 10);
                e_cnt = (e_ch == 3'd0) ? 8'd10 : 8'd0;
                checks++; if (out_ch !== e_ch) begin failures++; $display("FAIL basic_ch cyc=%0d got=%0d exp=%0d", cyc, out_ch, e_ch); end
                checks++; if (out_count !== e_cnt) begin failures++; $display("FAIL basic_count cyc=%0d got=%0d exp=%0d", cyc, out_count, e_cnt); end
                checks++; if (out_last !== (e_ch == 3'd7)) begin failures++; $display("FAIL basic_last cyc=%0d got=%0b exp=%0b", cyc, out_last, (e_ch == 3'd7)); end
            end
            step();
        end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL basic_overrun got=%0b exp=0", overrun); end
    endtask

    // 300 cycles of all-channel spikes must pin every count at 255.
    task automatic test_saturation();
        win_len = 16'd300; spike_in = 8'hFF; ena = 1'b1; out_ready = 1'b1;
        do_reset();
        while (cyc < 299) step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL sat_valid_early got=%0b exp=0", out_valid); end
        step();
        for (int k = 0; k < 8; k++) begin
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL sat_valid k=%0d got=%0b exp=1", k, out_valid); end
            checks++; if (out_ch !== 3'(k)) begin failures++; $display("FAIL sat_ch got=%0d exp=%0d", out_ch, k); end
            checks++; if (out_count !== 8'd255) begin failures++; $display("FAIL sat_count ch=%0d got=%0d exp=255", k, out_count); end
            step();
        end
    endtask

    // ch3 spikes on even cycles (20 per 40-cycle window); stall 5 cycles at ch3.
    task automatic test_backpressure();
        int         nrx;
        logic [7:0] e_cnt;
        win_len = 16'd40; spike_in = 8'h08; ena = 1'b1; out_ready = 1'b1;
        do_reset();
        nrx = 0;
        while (cyc < 56) begin
            spike_in  = (cyc % 2 == 0) ? 8'h08 : 8'h00;
            out_ready = !((cyc >= 43) && (cyc <= 47));
            if ((cyc >= 43) && (cyc <= 48)) begin
                checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid cyc=%0d got=%0b exp=1", cyc, out_valid); end
                checks++; if (out_ch !== 3'd3) begin failures++; $display("FAIL bp_hold_ch cyc=%0d got=%0d exp=3", cyc, out_ch); end
                checks++; if (out_count !== 8'd20) begin failures++; $display("FAIL bp_hold_count cyc=%0d got=%0d exp=20", cyc, out_count); end
            end
            if (out_valid && out_ready && nrx < 8) begin
                e_cnt = (nrx == 3) ? 8'd20 : 8'd0;
                checks++; if (out_ch !== 3'(nrx)) begin failures++; $display("FAIL bp_order got=%0d exp=%0d", out_ch, nrx); end
                checks++; if (out_count !== e_cnt) begin failures++; $display("FAIL bp_count ch=%0d got=%0d exp=%0d", nrx, out_count, e_cnt); end
                nrx++;
            end
            step();
        end
        checks++; if (nrx !== 8) begin failures++; $display("FAIL bp_entries got=%0d exp=8", nrx); end
    endtask

    // L=4, ch1 spikes, consumer stalled: second window end (cycle 7) overruns.
    task automatic test_overrun();
        logic [2:0] e_ch;
        logic [7:0] e_cnt;
        win_len = 16'd4; spike_in = 8'h02; ena = 1'b1; out_ready = 1'b0;
        do_reset();
        while (cyc < 4) step();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL ovr_valid got=%0b exp=1", out_valid); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_early got=%0b exp=0", overrun); end
        while (cyc < 8) step();
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_set got=%0b exp=1", overrun); end
        checks++; if (out_ch !== 3'd0) begin failures++; $display("FAIL ovr_pos got=%0d exp=0", out_ch); end
        out_ready = 1'b1;
        while (cyc < 16) begin
            e_ch  = 3'(cyc - 8);
            e_cnt = (e_ch == 3'd1) ? 8'd4 : 8'd0;
            checks++; if (out_ch !== e_ch) begin failures++; $display("FAIL ovr_drain_ch cyc=%0d got=%0d exp=%0d", cyc, out_ch, e_ch); end
            checks++; if (out_count !== e_cnt) begin failures++; $display("FAIL ovr_drain_count ch=%0d got=%0d exp=%0d", e_ch, out_count, e_cnt); end
            step();
        end
        // Window ending at cycle 15 coincides with the final handshake.
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL ovr_reload_valid got=%0b exp=1", out_valid); end
        checks++; if (out_ch !== 3'd0) begin failures++; $display("FAIL ovr_reload_ch got=%0d exp=0", out_ch); end
        step();
        checks++; if (out_ch !== 3'd1) begin failures++; $display("FAIL ovr_reload_ch1 got=%0d exp=1", out_ch); end
        checks++; if (out_count !== 8'd4) begin failures++; $display("FAIL ovr_reload_count got=%0d exp=4", out_count); end
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%0b exp=1", overrun); end
    endtask

    // win_len=0 (L=1), ena high on even cycles only: every count is 1.
    task automatic test_enable_gating();
        win_len = 16'd0; spike_in = 8'hFF; ena = 1'b1; out_ready = 1'b1;
        do_reset();
        while (cyc < 10) begin
            ena = (cyc % 2 == 0);
            if (cyc == 0) begin
                checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL gate_valid0 got=%0b exp=0", out_valid); end
            end else begin
                checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL gate_valid cyc=%0d got=%0b exp=1", cyc, out_valid); end
                checks++; if (out_ch !== 3'((cyc - 1) % 8)) begin failures++; $display("FAIL gate_ch cyc=%0d got=%0d exp=%0d", cyc, out_ch, (cyc - 1) % 8); end
                checks++; if (out_count !== 8'd1) begin failures++; $display("FAIL gate_count cyc=%0d got=%0d exp=1", cyc, out_count); end
            end
            step();
        end
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL gate_overrun got=%0b exp=1", overrun); end
        ena = 1'b1;
    endtask

    // Reset at out_ch=4 with overrun set; the next window starts from zero.
    task automatic test_reset_mid_drain();
        win_len = 16'd4; spike_in = 8'h01; ena = 1'b1; out_ready = 1'b0;
        do_reset();
        while (cyc < 8) step();
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL rmd_pre_overrun got=%0b exp=1", overrun); end
        out_ready = 1'b1;
        while (cyc < 12) step();
        checks++; if (out_ch !== 3'd4) begin failures++; $display("FAIL rmd_pre_ch got=%0d exp=4", out_ch); end
        rst_n = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rmd_valid got=%0b exp=0", out_valid); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL rmd_overrun got=%0b exp=0", overrun); end
        checks++; if (out_count !== 8'd0) begin failures++; $display("FAIL rmd_count got=%0d exp=0", out_count); end
        rst_n = 1'b1;
        cyc = 0;
        while (cyc < 4) step();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rmd_restart_valid got=%0b exp=1", out_valid); end
        checks++; if (out_ch !== 3'd0) begin failures++; $display("FAIL rmd_restart_ch got=%0d exp=0", out_ch); end
        checks++; if (out_count !== 8'd4) begin failures++; $display("FAIL rmd_restart_count got=%0d exp=4", out_count); end
    endtask

    // sequence and final report
    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_backpressure();
        test_overrun();
        test_enable_gating();
        test_reset_mid_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spike_rate_decoder.md
# spike_rate_decoder

Rate decoder for the spiking network's output side. It counts spikes per channel over a programmable window of clock cycles, snapshots the counts at the end of each window, and streams them out one channel per handshake. It sits downstream of the LIF layers, on the spike bus or the output-neuron spike line, and turns spike trains back into 8-bit intensity values for the host/IO logic.

## Interface
- N_CH, 8: number of spike channels.
- CNT_W, 8: count width per channel; counts saturate.
- WIN_W, 16: width of the window-length input.

- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- ena  in  1  window/count enable; low freezes counting only.
- spike_in  in  N_CH  one spike bit per channel, sampled every cycle.
- win_len  in  WIN_W  window length in cycles; 0 is treated as 1.
- out_valid  out  1  snapshot entry available.
- out_ready  in  1  consumer accepts the entry.
- out_ch  out  $clog2(N_CH)  channel index of the current entry.
- out_count  out  CNT_W  spike count for out_ch.
- out_last  out  1  high with the entry for channel N_CH-1.
- overrun  out  1  sticky; a window ended while the previous snapshot was still draining.

## Operation
- Window counter `wc` counts from 0 to L-1, where L is win_len (0 counts as 1).
  - L is latched when a window starts: at reset release and at each window end.
  - Changes to win_len in mid-window take effect from the next window.
- Each cycle with ena=1:
  - For each channel i, acc[i] increments when spike_in[i]=1.
  - acc[i] saturates at 2^CNT_W-1.
  - wc advances.
- Each cycle with ena=0: acc and wc hold. Spikes are ignored.
- End-of-window (EOW) is the ena=1 cycle with wc==L-1.
  - The spike on the EOW cycle is counted in the ending window.
  - On EOW, all acc clear to 0 and wc returns to 0.
- Drain FSM has two states, IDLE and DRAIN, with index idx.
  - IDLE, on EOW: snap[] ← final counts, idx ← 0, move to DRAIN.
  - In DRAIN: out_valid=1, out_ch=idx, out_count=snap[idx], out_last=(idx==N_CH-1).
  - A valid&&ready handshake advances idx.
  - A handshake with out_last=1 returns the FSM to IDLE.
- Overrun rules:
  - If EOW occurs in DRAIN without a simultaneous final handshake, the new counts are discarded and overrun is set.
  - In that case the acc still clear and snap[] plus the drain position are unchanged.
  - If EOW coincides with the final handshake, the new snapshot loads, the FSM stays in DRAIN with idx=0, and overrun is not set.
- overrun clears only on reset.
- Draining is independent of ena.
- Reset values: out_valid=0, out_ch=0, out_count=0, out_last=0, overrun=0, FSM=IDLE, acc=0, snap=0, wc=0.
- Reset mid-window or mid-drain discards everything. There is no partial output.

## Timing
- With ena held high from reset release, the first EOW is cycle L-1; cycle 0 is the first cycle with rst_n=1.
- out_valid rises on the cycle after EOW, with out_ch=0.
- Throughput is one entry per cycle when out_ready=1.
  - With out_ready held high, a full drain takes N_CH cycles.
  - L ≥ N_CH+1 never overruns when out_ready is always high.
- Under out_ready=0, out_ch, out_count and out_last hold stable until the handshake.
- out_valid never drops without a handshake, except on reset.
- All outputs are registered. There is no combinational path from out_ready to out_valid, out_ch or out_count.

## Structure
- Shared package lif_pkg:
  - default N_CH, CNT_W and WIN_W constants;
  - drain state enum (IDLE, DRAIN);
  - saturating-increment function.
- Sub-module spike_counter: one saturating channel accumulator with inc, clear and en inputs. It is instantiated N_CH times by generate.
- Top level holds the window counter, the snapshot registers and the drain FSM.

## Test plan
- Basic count: win_len=10, spike_in=8'h01 constant, ena=1, out_ready=1.
  - out_valid rises at cycle 10.
  - ch0 count=10, ch1..7 count=0.
  - out_last with ch7 at cycle 17.
- Saturation: win_len=300, spike_in=8'hFF. All eight counts read 255.
- Backpressure: win_len=40, alternating spikes on ch3 (20/window), out_ready=0 for 5 cycles at ch3.
  - out_ch=3 and out_count=20 hold stable for those cycles.
  - All 8 entries arrive in order with none lost.
- Overrun: win_len=4, spike_in=8'h02, out_ready=0.
  - overrun set at cycle 7.
  - Draining later yields the first window's counts (ch1=4).
  - overrun stays set.
- Enable gating: win_len=0, ena toggling every cycle, spike_in=8'hFF.
  - Each enabled cycle is an EOW with count 1.
  - Disabled cycles add nothing.
- Reset mid-drain: rst_n=0 at out_ch=4 → next cycle out_valid=0, overrun=0. The next window restarts from count 0.
